// File: rtl/dmem_resp.sv
// dmem_resp: multi-cycle data-memory responder (valid/ready request, one-cycle response pulse).
// Optional per-byte store masking is enabled by defining DMEM_BE_EN; otherwise stores write full words.
module dmem_resp #(
  parameter int DEPTH = 128,
  parameter int WAIT  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW          = $clog2(DEPTH);
  localparam logic [29:0] DEPTH_WORDS = 30'(DEPTH);
  localparam logic [3:0]  WAIT_CNT    = 4'(WAIT);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    stateReg, stateNext;
  logic [3:0]    cntReg, cntNext;
  logic          weReg;
  logic [31:0]   addrReg;
  logic [31:0]   wdataReg;
  logic          loadHitReg;
  logic          errReg;
  logic          accept;
  logic          commit;
  logic          addrErr;
  logic          doWrite;
  logic [AW-1:0] wordIdx;
  logic [3:0]    laneEn;
  logic [31:0]   readWord;

  assign accept    = (stateReg == IDLE) && req_valid;
  assign commit    = (stateReg == BUSY) && (cntReg == 4'd0);
  assign addrErr   = (addrReg[1:0] != 2'b00) || (addrReg[31:2] >= DEPTH_WORDS);
  assign wordIdx   = addrReg[AW+1:2];
  assign doWrite   = commit && weReg && !addrErr;

  assign req_ready = (stateReg == IDLE);
  assign rsp_valid = (stateReg == RESP);
  assign rsp_err   = errReg;
  // Read data is only exposed after a successful load so stale lane registers never leak out.
  assign rsp_rdata = loadHitReg ? readWord : 32'd0;

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    case (stateReg)
      IDLE: begin
        if (accept) begin
          stateNext = BUSY;
          cntNext   = WAIT_CNT;
        end
      end
      BUSY: begin
        if (cntReg == 4'd0) begin
          stateNext = RESP;
        end else begin
          cntNext = cntReg - 4'd1;
        end
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg   <= IDLE;
      cntReg     <= 4'd0;
      weReg      <= 1'b0;
      addrReg    <= 32'd0;
      wdataReg   <= 32'd0;
      loadHitReg <= 1'b0;
      errReg     <= 1'b0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      if (accept) begin
        weReg    <= req_we;
        addrReg  <= req_addr;
        wdataReg <= req_wdata;
      end
      if (commit) begin
        loadHitReg <= !weReg && !addrErr;
        errReg     <= addrErr;
      end
    end
  end

`ifdef DMEM_BE_EN
  logic [3:0] beReg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beReg <= 4'd0;
    end else if (accept) begin
      beReg <= req_be;
    end
  end

  assign laneEn = beReg;
`else
  // Byte enables stay on the port for compatibility but every store covers the whole word.
  logic unusedBe;
  assign unusedBe = ^req_be;
  assign laneEn   = 4'hF;
`endif

  // One byte-wide array per lane keeps masked writes simple and maps onto block RAM with a registered read.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gLane
      logic [7:0] laneMem [DEPTH];
      logic [7:0] rdByte;

      always_ff @(posedge clk) begin
        if (commit) begin
          rdByte <= laneMem[wordIdx];
        end
        if (doWrite && laneEn[gi]) begin
          laneMem[wordIdx] <= wdataReg[8*gi +: 8];
        end
      end
    end
  endgenerate

  assign readWord = {gLane[3].rdByte, gLane[2].rdByte, gLane[1].rdByte, gLane[0].rdByte};

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: table of store/load vectors on a WAIT=2 instance,
// plus hand-written back-to-back and mid-operation reset sequences (the latter on a WAIT=3 instance).
module tb_dmem_resp;

  localparam int DEPTH  = 128;
  localparam int WAIT_A = 2;
  localparam int WAIT_B = 3;

`ifdef DMEM_BE_EN
  localparam logic [31:0] BE_EXP  = 32'h11BB33DD;
  localparam logic [31:0] BE0_EXP = 32'h55667788;
`else
  localparam logic [31:0] BE_EXP  = 32'hAABBCCDD;
  localparam logic [31:0] BE0_EXP = 32'h99999999;
`endif

  typedef struct {
    string       name;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] expData;
    bit          expErr;
  } vec_t;

  logic        clk;
  logic        rstN      [2];
  logic        reqValid  [2];
  logic        reqReady  [2];
  logic        reqWe     [2];
  logic [31:0] reqAddr   [2];
  logic [31:0] reqWdata  [2];
  logic [3:0]  reqBe     [2];
  logic        rspValid  [2];
  logic [31:0] rspRdata  [2];
  logic        rspErr    [2];

  int tests;
  int fails;
  vec_t vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_resp #(.DEPTH(DEPTH), .WAIT(WAIT_A)) u_dutA (
    .clk(clk), .rst_n(rstN[0]),
    .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_we(reqWe[0]),
    .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]), .req_be(reqBe[0]),
    .rsp_valid(rspValid[0]), .rsp_rdata(rspRdata[0]), .rsp_err(rspErr[0])
  );

  dmem_resp #(.DEPTH(DEPTH), .WAIT(WAIT_B)) u_dutB (
    .clk(clk), .rst_n(rstN[1]),
    .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_we(reqWe[1]),
    .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]), .req_be(reqBe[1]),
    .rsp_valid(rspValid[1]), .rsp_rdata(rspRdata[1]), .rsp_err(rspErr[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic addVec(input string name, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] expData, input bit expErr);
    vec_t v;
    v.name = name; v.we = we; v.addr = addr; v.wdata = wdata;
    v.be = be; v.expData = expData; v.expErr = expErr;
    vecs.push_back(v);
  endtask

  // One request on instance d: wait for acceptance, measure latency, check the response and its one-cycle width.
  task automatic txn(input int d, input string name, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     input logic [31:0] expData, input bit expErr);
    bit acc;
    int lat;
    int expLat;
    logic [31:0] rdata;
    logic err;
    acc    = 1'b0;
    lat    = -1;
    rdata  = 32'd0;
    err    = 1'b0;
    expLat = ((d == 0) ? WAIT_A : WAIT_B) + 1;
    @(posedge clk); #1;
    reqValid[d] = 1'b1; reqWe[d] = we; reqAddr[d] = addr; reqWdata[d] = wdata; reqBe[d] = be;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      if (reqReady[d]) acc = 1'b1;
      @(posedge clk);
    end
    #1;
    // Scramble the request fields after acceptance; the latched copy must be used.
    reqValid[d] = 1'b0; reqWe[d] = ~we; reqAddr[d] = 32'hFFFF_FFF3; reqWdata[d] = 32'h5A5A_5A5A; reqBe[d] = ~be;
    check($sformatf("%s accept", name), 32'(acc), 32'd1);
    if (acc) begin
      for (int i = 1; i <= 40; i++) begin
        @(negedge clk);
        if (rspValid[d]) begin
          lat   = i - 1;
          rdata = rspRdata[d];
          err   = rspErr[d];
          break;
        end
      end
      check($sformatf("%s latency", name), 32'(lat), 32'(expLat));
      check($sformatf("%s rdata", name), rdata, expData);
      check($sformatf("%s err", name), 32'(err), 32'(expErr));
      @(negedge clk);
      check($sformatf("%s pulse end {valid,ready}", name), {30'd0, rspValid[d], reqReady[d]}, 32'd1);
      $display("[TB] %s: we=%0d addr=0x%08h be=%h -> rdata=0x%08h err=%0d lat=%0d",
               name, we, addr, be, rdata, err, lat);
    end
  endtask

  task automatic checkIdle(input int d, input string tag);
    check($sformatf("%s ready", tag), 32'(reqReady[d]), 32'd1);
    check($sformatf("%s rsp_valid", tag), 32'(rspValid[d]), 32'd0);
    check($sformatf("%s rsp_rdata", tag), rspRdata[d], 32'd0);
    check($sformatf("%s rsp_err", tag), 32'(rspErr[d]), 32'd0);
  endtask

  initial begin
    int t1;
    int t2;
    int lowCnt;
    bit rdy;
    bit seen;
    tests = 0;
    fails = 0;
    for (int d = 0; d < 2; d++) begin
      rstN[d] = 1'b0; reqValid[d] = 1'b0; reqWe[d] = 1'b0;
      reqAddr[d] = 32'd0; reqWdata[d] = 32'd0; reqBe[d] = 4'd0;
    end

    addVec("st w0",        1'b1, 32'h0000_0000, 32'h0BAD_F00D, 4'hF, 32'h0,         1'b0);
    addVec("st 0x10",      1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0);
    addVec("ld 0x10",      1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0);
    addVec("st 0x20 full", 1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0,         1'b0);
    addVec("st 0x20 be5",  1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0,         1'b0);
    addVec("ld 0x20",      1'b0, 32'h0000_0020, 32'h0,         4'hF, BE_EXP,        1'b0);
    addVec("ld misalign",  1'b0, 32'h0000_0012, 32'h0,         4'hF, 32'h0,         1'b1);
    addVec("st range",     1'b1, 32'(DEPTH*4),  32'h1234_5678, 4'hF, 32'h0,         1'b1);
    addVec("ld w0",        1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'h0BAD_F00D, 1'b0);
    addVec("st misalign",  1'b1, 32'h0000_0011, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1);
    addVec("ld 0x10 again",1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0);
    addVec("st last",      1'b1, 32'h0000_01FC, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0);
    addVec("ld last",      1'b0, 32'h0000_01FC, 32'h0,         4'hF, 32'hCAFE_F00D, 1'b0);
    addVec("st 0x24",      1'b1, 32'h0000_0024, 32'h5566_7788, 4'hF, 32'h0,         1'b0);
    addVec("st 0x24 be0",  1'b1, 32'h0000_0024, 32'h9999_9999, 4'h0, 32'h0,         1'b0);
    addVec("ld 0x24",      1'b0, 32'h0000_0024, 32'h0,         4'hF, BE0_EXP,       1'b0);
    addVec("ld addr3",     1'b0, 32'h0000_0003, 32'h0,         4'hF, 32'h0,         1'b1);
    addVec("ld high bit",  1'b0, 32'h8000_0010, 32'h0,         4'hF, 32'h0,         1'b1);

    // Reset state, then release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkIdle(0, "reset A");
    checkIdle(1, "reset B");
    rstN[0] = 1'b1; rstN[1] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkIdle(0, "post-reset A");
    $display("[TB] reset: ready=%0d rsp_valid=%0d", reqReady[0], rspValid[0]);

    foreach (vecs[k]) begin
      txn(0, vecs[k].name, vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].be,
          vecs[k].expData, vecs[k].expErr);
    end

    // Back-to-back with req_valid held high: the second store waits WAIT+3 edges.
    t1 = -1; t2 = -1; lowCnt = 0;
    @(posedge clk); #1;
    reqValid[0] = 1'b1; reqWe[0] = 1'b1; reqAddr[0] = 32'h30; reqWdata[0] = 32'h0101_0101; reqBe[0] = 4'hF;
    for (int t = 1; t <= 60 && t2 < 0; t++) begin
      @(negedge clk);
      rdy = reqReady[0];
      if (t1 >= 0 && !rdy) lowCnt++;
      @(posedge clk);
      if (rdy) begin
        if (t1 < 0) begin
          t1 = t;
          #1;
          reqAddr[0] = 32'h34; reqWdata[0] = 32'h0202_0202;
        end else begin
          t2 = t;
        end
      end
    end
    #1;
    reqValid[0] = 1'b0;
    check("b2b accept gap", 32'(t2 - t1), 32'(WAIT_A + 3));
    check("b2b ready low cycles", 32'(lowCnt), 32'(WAIT_A + 2));
    $display("[TB] b2b: first accept edge %0d, second %0d, ready low %0d cycles", t1, t2, lowCnt);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (rspValid[0]) seen = 1'b1;
    end
    check("b2b second response", 32'(seen), 32'd1);
    txn(0, "ld 0x30", 1'b0, 32'h30, 32'h0, 4'hF, 32'h0101_0101, 1'b0);
    txn(0, "ld 0x34", 1'b0, 32'h34, 32'h0, 4'hF, 32'h0202_0202, 1'b0);

    // Reset during BUSY on the WAIT=3 instance: uncommitted store discarded.
    txn(1, "B st 0x04", 1'b1, 32'h04, 32'h0,         4'hF, 32'h0,         1'b0);
    txn(1, "B st 0x08", 1'b1, 32'h08, 32'h0000_0077, 4'hF, 32'h0,         1'b0);
    txn(1, "B ld 0x08", 1'b0, 32'h08, 32'h0,         4'hF, 32'h0000_0077, 1'b0);
    @(posedge clk); #1;
    reqValid[1] = 1'b1; reqWe[1] = 1'b1; reqAddr[1] = 32'h04; reqWdata[1] = 32'hFFFF_FFFF; reqBe[1] = 4'hF;
    @(negedge clk);
    check("B midop ready before accept", 32'(reqReady[1]), 32'd1);
    @(posedge clk); #1;
    reqValid[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("B midop busy ready", 32'(reqReady[1]), 32'd0);
    check("B midop held rdata", rspRdata[1], 32'h0000_0077);
    rstN[1] = 1'b0;
    #1;
    checkIdle(1, "B midop reset");
    $display("[TB] B mid-op reset: ready=%0d rsp_valid=%0d rdata=0x%08h", reqReady[1], rspValid[1], rspRdata[1]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstN[1] = 1'b1;
    txn(1, "B ld 0x04 after reset", 1'b0, 32'h04, 32'h0, 4'hF, 32'h0, 1'b0);
    txn(1, "B ld 0x08 after reset", 1'b0, 32'h08, 32'h0, 4'hF, 32'h0000_0077, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule
